// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serialises the low len bits of a latched pattern MSB-first on w,
// repeating it reps times (0 = until stop) with GAP idle cycles between copies.
// Moore FSM: every output is a register updated together with the state.
module seq_pattern_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned REPW  = 4,
    parameter int unsigned GAP   = 0
) (
    input  logic                       Clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic [WIDTH-1:0]           pattern,
    input  logic [$clog2(WIDTH+1)-1:0] len,
    input  logic [REPW-1:0]            reps,
    output logic                       w,
    output logic                       valid,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int unsigned LW = $clog2(WIDTH + 1);
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // Gap counter runs 0..GAP-1; keep at least one bit so GAP=0 still elaborates.
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [GW-1:0] GapLast = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [REPW:0] RepOne  = (REPW + 1)'(1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StGapw  = 2'b11,
        StDone  = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  pat_q, pat_d;
    logic [LW-1:0]     len_q, len_d;
    logic [REPW-1:0]   reps_q, reps_d;
    logic [LW-1:0]     idx_q, idx_d;
    logic [REPW-1:0]   rep_cnt_q, rep_cnt_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic              w_q, w_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              len_ok;
    logic              last_bit;
    logic              more_reps;
    logic [IW-1:0]     first_sel;
    logic [IW-1:0]     restart_sel;
    logic [IW-1:0]     next_sel;

    // Decode helpers: legality of the requested length, bit positions, repeat status.
    always_comb begin
        len_ok      = (len != '0) && (len <= LW'(WIDTH));
        first_sel   = IW'(len - LW'(1));
        restart_sel = IW'(len_q - LW'(1));
        // Position of the bit after the one now on w: len-1-(idx+1).
        next_sel    = IW'(len_q - idx_q - LW'(2));
        last_bit    = (idx_q == (len_q - LW'(1)));
        // reps=0 never terminates; the counter is frozen then so it cannot wrap.
        more_reps   = (reps_q == '0) || (({1'b0, rep_cnt_q} + RepOne) < {1'b0, reps_q});
    end

    // Next-state and next-output logic; outputs describe the cycle after the edge.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        reps_d    = reps_q;
        idx_d     = idx_q;
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;
        w_d       = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            StIdle: begin
                // stop has priority: a simultaneous start is dropped silently.
                if (start && !stop) begin
                    if (len_ok) begin
                        state_d   = StShift;
                        pat_d     = pattern;
                        len_d     = len;
                        reps_d    = reps;
                        idx_d     = '0;
                        rep_cnt_d = '0;
                        gap_cnt_d = '0;
                        w_d       = pattern[first_sel];
                        valid_d   = 1'b1;
                        busy_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            StShift: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (last_bit) begin
                    if (reps_q != '0) begin
                        rep_cnt_d = rep_cnt_q + REPW'(1);
                    end
                    if (!more_reps) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else if (GAP > 0) begin
                        state_d   = StGapw;
                        gap_cnt_d = '0;
                        busy_d    = 1'b1;
                    end else begin
                        // Back-to-back copy: first bit follows the last with no hole.
                        idx_d   = '0;
                        w_d     = pat_q[restart_sel];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end else begin
                    idx_d   = idx_q + LW'(1);
                    w_d     = pat_q[next_sel];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            StGapw: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (gap_cnt_q == GapLast) begin
                    state_d = StShift;
                    idx_d   = '0;
                    w_d     = pat_q[restart_sel];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                    busy_d    = 1'b1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, latched request and registered outputs; reset clears everything at once.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pat_q     <= '0;
            len_q     <= '0;
            reps_q    <= '0;
            idx_q     <= '0;
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
            w_q       <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            reps_q    <= reps_d;
            idx_q     <= idx_d;
            rep_cnt_q <= rep_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            w_q       <= w_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign w     = w_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one DUT with GAP=0 and one with GAP=2.
module tb_seq_pattern_tx;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned REPW  = 4;
    localparam int unsigned LW    = $clog2(WIDTH + 1);

    // Expected {w, valid, busy, done, err}
    localparam logic [4:0] IDL = 5'b00000;
    localparam logic [4:0] B1  = 5'b11100;
    localparam logic [4:0] B0  = 5'b01100;
    localparam logic [4:0] DN  = 5'b00010;
    localparam logic [4:0] ER  = 5'b00001;
    localparam logic [4:0] GP  = 5'b00100;

    logic             Clock = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] pattern;
    logic [LW-1:0]    len;
    logic [REPW-1:0]  reps;
    logic             w, valid, busy, done, err;
    logic             gw, gvalid, gbusy, gdone, gerr;
    logic [4:0]       obs, gobs;

    int checks = 0;
    int errors = 0;
    int zcount = 0;
    logic [3:0] zsh = 4'b0000;

    assign obs  = {w, valid, busy, done, err};
    assign gobs = {gw, gvalid, gbusy, gdone, gerr};

    seq_pattern_tx #(.WIDTH(WIDTH), .REPW(REPW), .GAP(0)) u_dut (
        .Clock(Clock), .reset(reset), .start(start), .stop(stop),
        .pattern(pattern), .len(len), .reps(reps),
        .w(w), .valid(valid), .busy(busy), .done(done), .err(err)
    );

    seq_pattern_tx #(.WIDTH(WIDTH), .REPW(REPW), .GAP(2)) u_dut_gap (
        .Clock(Clock), .reset(reset), .start(start), .stop(stop),
        .pattern(pattern), .len(len), .reps(reps),
        .w(gw), .valid(gvalid), .busy(gbusy), .done(gdone), .err(gerr)
    );

    always #5 Clock = ~Clock;

    // Downstream 1011 detector (overlapping) fed by valid bits of the GAP=0 DUT.
    always @(negedge Clock) begin
        if (valid) begin
            zsh = {zsh[2:0], w};
            if (zsh == 4'b1011) zcount++;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        pattern = '0; len = '0; reps = '0;
        #2;
        checks++;
        if (obs !== IDL) begin
            errors++; $display("FAIL reset_async: got %b expected %b", obs, IDL);
        end
        checks++;
        if (gobs !== IDL) begin
            errors++; $display("FAIL reset_async_gap: got %b expected %b", gobs, IDL);
        end
        tick(); tick();
        checks++;
        if (obs !== IDL) begin
            errors++; $display("FAIL reset_held: got %b expected %b", obs, IDL);
        end
        reset = 1'b0;
    endtask

    // 0B, len 4, reps 1 -> 1,0,1,1 then done then idle; starts at first edge after reset.
    task automatic test_single();
        logic [4:0] ev [7];
        ev = '{B1, B0, B1, B1, DN, IDL, IDL};
        pattern = 8'h0B; len = 4'd4; reps = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        pattern = 8'hFF;
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (obs !== ev[c]) begin
                errors++; $display("FAIL single cycle %0d: got %b expected %b", c + 1, obs, ev[c]);
            end
            tick();
        end
    endtask

    task automatic test_reps3();
        logic [3:0] p;
        logic [4:0] e;
        int z0;
        p = 4'b1011;
        z0 = zcount;
        pattern = 8'h0B; len = 4'd4; reps = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (c < 12) e = p[3 - (c % 4)] ? B1 : B0;
            else if (c == 12) e = DN;
            else e = IDL;
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL reps3 cycle %0d: got %b expected %b", c + 1, obs, e);
            end
            tick();
        end
        checks++;
        if (zcount - z0 !== 3) begin
            errors++; $display("FAIL reps3_detect: got %0d expected 3", zcount - z0);
        end
    endtask

    // Continuous A5 at full length, stop raised in cycle 10.
    task automatic test_continuous();
        logic [7:0] p;
        logic [4:0] e;
        p = 8'hA5;
        pattern = 8'hA5; len = 4'd8; reps = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 14; c++) begin
            e = (c < 10) ? (p[7 - (c % 8)] ? B1 : B0) : IDL;
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL continuous cycle %0d: got %b expected %b", c + 1, obs, e);
            end
            if (c == 9) stop = 1'b1;
            if (c == 10) stop = 1'b0;
            tick();
        end
    endtask

    // len=1, reps=0: more than 2^REPW copies must not terminate.
    task automatic test_no_wrap();
        pattern = 8'h01; len = 4'd1; reps = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (obs !== B1) begin
                errors++; $display("FAIL no_wrap cycle %0d: got %b expected %b", c + 1, obs, B1);
            end
            if (c == 39) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        checks++;
        if (obs !== IDL) begin
            errors++; $display("FAIL no_wrap_stop: got %b expected %b", obs, IDL);
        end
        tick();
    endtask

    // len=1, reps=15 (max): exactly 15 zero bits then done.
    task automatic test_max_reps();
        logic [4:0] e;
        pattern = 8'hFE; len = 4'd1; reps = 4'd15; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 17; c++) begin
            e = (c < 15) ? B0 : ((c == 15) ? DN : IDL);
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL max_reps cycle %0d: got %b expected %b", c + 1, obs, e);
            end
            tick();
        end
    endtask

    task automatic test_err();
        logic [4:0] ev [6];
        logic [LW-1:0] lv [6];
        logic sv [6];
        logic pv [6];
        ev = '{ER, IDL, ER, IDL, IDL, IDL};
        lv = '{4'd0, 4'd0, 4'd9, 4'd9, 4'd4, 4'd4};
        sv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        pv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        pattern = 8'h0B; reps = 4'd1;
        for (int c = 0; c < 6; c++) begin
            len = lv[c]; start = sv[c]; stop = pv[c];
            tick();
            checks++;
            if (obs !== ev[c]) begin
                errors++; $display("FAIL err step %0d: got %b expected %b", c, obs, ev[c]);
            end
        end
        start = 1'b0; stop = 1'b0;
    endtask

    // New start and input changes while busy are ignored; one done pulse.
    task automatic test_busy_ignore();
        logic [4:0] ev [11];
        int dones;
        ev = '{B1, B0, B1, B1, B1, B0, B1, B1, DN, IDL, IDL};
        dones = 0;
        pattern = 8'h0B; len = 4'd4; reps = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 11; c++) begin
            checks++;
            if (obs !== ev[c]) begin
                errors++; $display("FAIL busy_ignore cycle %0d: got %b expected %b", c + 1, obs, ev[c]);
            end
            if (done) dones++;
            if (c == 1) begin
                pattern = 8'hF0; len = 4'd3; reps = 4'd5; start = 1'b1;
            end
            if (c == 4) start = 1'b0;
            tick();
        end
        checks++;
        if (dones !== 1) begin
            errors++; $display("FAIL busy_ignore_dones: got %0d expected 1", dones);
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] ev [6];
        ev = '{B1, B0, B1, B1, DN, IDL};
        pattern = 8'h0B; len = 4'd4; reps = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        checks++;
        if (obs !== B1) begin
            errors++; $display("FAIL reset_mid_pre: got %b expected %b", obs, B1);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== IDL) begin
            errors++; $display("FAIL reset_mid_async: got %b expected %b", obs, IDL);
        end
        tick();
        checks++;
        if (obs !== IDL) begin
            errors++; $display("FAIL reset_mid_held: got %b expected %b", obs, IDL);
        end
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (obs !== ev[c]) begin
                errors++; $display("FAIL reset_mid_after cycle %0d: got %b expected %b", c + 1, obs, ev[c]);
            end
            tick();
        end
    endtask

    // GAP=2 instance vs GAP=0 instance on the same 101 x2 request, then stop inside a gap.
    task automatic test_gap();
        logic [4:0] eg [10];
        logic [4:0] em [10];
        logic [4:0] eg2 [6];
        eg  = '{B1, B0, B1, GP, GP, B1, B0, B1, DN, IDL};
        em  = '{B1, B0, B1, B1, B0, B1, DN, IDL, IDL, IDL};
        eg2 = '{B1, B0, B1, GP, IDL, IDL};
        reset = 1'b1;
        #2;
        tick();
        reset = 1'b0;
        pattern = 8'h05; len = 4'd3; reps = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (gobs !== eg[c]) begin
                errors++; $display("FAIL gap2 cycle %0d: got %b expected %b", c + 1, gobs, eg[c]);
            end
            checks++;
            if (obs !== em[c]) begin
                errors++; $display("FAIL gap0 cycle %0d: got %b expected %b", c + 1, obs, em[c]);
            end
            tick();
        end
        reps = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (gobs !== eg2[c]) begin
                errors++; $display("FAIL gap_stop cycle %0d: got %b expected %b", c + 1, gobs, eg2[c]);
            end
            if (c == 3) stop = 1'b1;
            if (c == 4) stop = 1'b0;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reps3();
        test_continuous();
        test_no_wrap();
        test_max_reps();
        test_err();
        test_busy_ignore();
        test_reset_mid();
        test_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter WIDTH, default 8, maximum pattern length in bits.
REQ-002 Parameter REPW, default 4, width of the repeat-count input.
REQ-003 Parameter GAP, default 0, number of idle cycles (w=0, valid=0) inserted between repetitions.
REQ-004 Clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to begin transmission; sampled only in IDLE.
REQ-007 stop  input  1  abort request; sampled in every state.
REQ-008 pattern  input  WIDTH  bit pattern; the low len bits are sent MSB-first.
REQ-009 len  input  $clog2(WIDTH+1)  number of bits to send, legal range 1..WIDTH.
REQ-010 reps  input  REPW  repetition count; 0 means continuous until stop.
REQ-011 w  output  1  serial data bit, driven for a downstream sequence detector.
REQ-012 valid  output  1  high in every cycle in which w carries a pattern bit.
REQ-013 busy  output  1  high from the cycle after start is accepted until the cycle before return to IDLE.
REQ-014 done  output  1  one-cycle pulse on normal completion.
REQ-015 err  output  1  one-cycle pulse when start is rejected for an illegal len.

Function
REQ-016 The block SHALL be a Moore FSM: all outputs SHALL be decoded from registered state only, never directly from inputs.
REQ-017 States and encoding SHALL be: IDLE=2'b00, SHIFT=2'b01, GAPW=2'b11, DONE=2'b10.
REQ-018 IDLE: start=1, stop=0, 1<=len<=WIDTH -> latch pattern, len and reps, clear bit index and repetition counter, go to SHIFT.
REQ-019 IDLE: start=1 with len=0 or len>WIDTH -> stay in IDLE and pulse err for one cycle; busy stays 0.
REQ-020 IDLE: start and stop both high -> stop wins; start is ignored with no err.
REQ-021 Latency: if start is accepted at edge k, the first bit SHALL appear on w with valid=1 in the cycle after edge k.
REQ-022 SHIFT: w SHALL equal latched pattern[len-1-idx]; idx SHALL increment once per cycle; each bit SHALL be held for exactly one cycle.
REQ-023 SHIFT, last bit (idx=len-1): go to GAPW if GAP>0 and more repetitions remain, go to SHIFT with idx=0 if GAP=0 and more remain, else go to DONE.
REQ-024 With GAP=0, repetitions SHALL be sent back-to-back with no idle cycle between them.
REQ-025 GAPW: w=0 and valid=0 for exactly GAP cycles, then go to SHIFT with idx=0.
REQ-026 Repetition counting: reps=N (N>0) SHALL send exactly N copies; reps=0 SHALL repeat indefinitely, and the repetition counter SHALL NOT wrap into termination.
REQ-027 DONE: done=1, w=0, valid=0, busy=0 for one cycle, then go to IDLE.
REQ-028 stop=1 in SHIFT or GAPW SHALL force IDLE at the next edge; the next cycle has w=0, valid=0, busy=0, and no done pulse; a partial pattern is discarded.
REQ-029 Changes on pattern, len and reps while busy=1 SHALL have no effect; start while busy=1 SHALL be ignored.
REQ-030 In IDLE and DONE, w SHALL be 0; w SHALL be 0 whenever valid=0.
REQ-031 Illegal state encodings SHALL recover to IDLE at the next edge.

Reset
REQ-032 reset=1 SHALL asynchronously force IDLE and clear all latched registers and counters.
REQ-033 While reset=1, outputs SHALL be w=0, valid=0, busy=0, done=0, err=0.
REQ-034 On reset deassertion, the block SHALL accept start at the first rising edge.
REQ-035 Reset asserted mid-transmission SHALL abort immediately, with no done pulse.

Verification
REQ-036 pattern=8'h0B, len=4, reps=1, start pulsed at edge 0 -> cycles 1-4: w=1,0,1,1 with valid=1; cycle 5: done=1; cycle 6: IDLE.
REQ-037 Same pattern with reps=3 and GAP=0 -> 12 consecutive valid bits 1011 1011 1011; the attached 1011 detector asserts z three times.
REQ-038 reps=0, stop raised in cycle 10 -> from cycle 11, w=0, valid=0, busy=0; done never asserted.
REQ-039 start with len=0, then start with len=9 (WIDTH=8) -> err pulses once for each request; busy stays 0 throughout.
REQ-040 reset asserted during the bit-2 cycle -> all outputs 0 without waiting for a clock edge; after release, a new start sends the full pattern correctly.
REQ-041 start pulsed again, with a different pattern, while busy=1 -> the original transmission completes unchanged, followed by a single done pulse.
